// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
// Channel codes, word-length helper and boundary decision enum.
package i2s_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SYNC_DEF   = 2;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int IDX_W_DEF = $clog2(DATA_W_DEF + 1);

  // Outcome of one WS boundary, exactly one per boundary rise.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_SYNC,
    EV_SHORT,
    EV_LEFT,
    EV_PAIR,
    EV_ORPHAN
  } ev_e;

  function automatic int idx_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchroniser for one asynchronous I2S line.
// With EDGE set, q is a one-cycle rising-edge pulse instead of the level.
module i2s_rx_sync
  import i2s_pkg::*;
#(
  parameter int STAGES = SYNC_DEF,
  parameter bit EDGE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], raw};
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic prev;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev <= 1'b0;
        end else begin
          prev <= ff[STAGES-1];
        end
      end

      assign q = ff[STAGES-1] & ~prev;
    end else begin : g_lvl
      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversampled BCLK/WS/SD, MSB-first deserialiser,
// left/right pairing with registered valid and frame-error strobes.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              i2s_bclk_in,
  input  logic              i2s_ws_in,
  input  logic              i2s_d_in,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              sample_valid_out,
  output logic              frame_err_out
);

  localparam int IW = idx_w(DATA_W);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DATA_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  logic rise;
  logic ws_s;
  logic d_s;

  i2s_rx_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b1)
  ) u_bclk (
    .clk (clk_in),
    .rst (reset_in),
    .raw (i2s_bclk_in),
    .q   (rise)
  );

  i2s_rx_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b0)
  ) u_ws (
    .clk (clk_in),
    .rst (reset_in),
    .raw (i2s_ws_in),
    .q   (ws_s)
  );

  i2s_rx_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b0)
  ) u_d (
    .clk (clk_in),
    .rst (reset_in),
    .raw (i2s_d_in),
    .q   (d_s)
  );

  logic              ws_prev;
  logic              synced;
  logic              left_ok;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] left_hold;

  logic              bnd;
  logic              take;
  logic              full;
  logic [DATA_W-1:0] word;
  ev_e               ev;

  // Bits past DATA_W are dropped, so the word keeps its first DATA_W bits.
  always_comb begin
    bnd  = (ws_s != ws_prev);
    take = (idx < IDX_MAX);
    full = (idx >= IDX_LAST);
    word = take ? {sh[DATA_W-2:0], d_s} : sh;
  end

  always_comb begin
    ev = EV_NONE;
    if (rise && bnd) begin
      if (!synced) begin
        ev = EV_SYNC;
      end else if (!full) begin
        ev = EV_SHORT;
      end else if (ws_prev == WS_LEFT) begin
        ev = EV_LEFT;
      end else if (left_ok) begin
        ev = EV_PAIR;
      end else begin
        ev = EV_ORPHAN;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ws_prev          <= WS_LEFT;
      synced           <= 1'b0;
      left_ok          <= 1'b0;
      idx              <= '0;
      sh               <= '0;
      left_hold        <= '0;
      left_out         <= '0;
      right_out        <= '0;
      sample_valid_out <= 1'b0;
      frame_err_out    <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      frame_err_out    <= 1'b0;
      if (rise) begin
        ws_prev <= ws_s;
        if (bnd) begin
          idx <= '0;
          sh  <= '0;
        end else if (take) begin
          idx <= idx + IW'(1);
          sh  <= word;
        end
      end
      unique case (ev)
        EV_NONE: ;
        EV_SYNC: synced <= 1'b1;
        EV_SHORT: begin
          frame_err_out <= 1'b1;
          if (ws_prev == WS_RIGHT) begin
            left_ok <= 1'b0;
          end
        end
        EV_LEFT: begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end
        EV_PAIR: begin
          left_out         <= left_hold;
          right_out        <= word;
          sample_valid_out <= 1'b1;
          left_ok          <= 1'b0;
        end
        EV_ORPHAN: frame_err_out <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: model Philips transmitter driving BCLK/WS/SD,
// pairs pushed to a scoreboard and popped on each valid strobe.
module tb_i2s_rx;

  logic        clk;
  logic        rst;
  logic        bclk;
  logic        ws;
  logic        d;
  logic [15:0] left;
  logic [15:0] right;
  logic        valid;
  logic        err;

  i2s_rx #(
    .DATA_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in           (clk),
    .reset_in         (rst),
    .i2s_bclk_in      (bclk),
    .i2s_ws_in        (ws),
    .i2s_d_in         (d),
    .left_out         (left),
    .right_out        (right),
    .sample_valid_out (valid),
    .frame_err_out    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  pair_t q[$];
  pair_t p;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int half   = 4;
  int edge_cyc = 0;
  int err_cnt  = 0;
  bit lat_on   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic w, input logic b, input bit st);
    @(negedge clk);
    bclk = 1'b0;
    ws   = w;
    d    = b;
    repeat (half - 1) @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    if (st) edge_cyc = cyc;
    repeat (half - 1) @(negedge clk);
  endtask

  // WS flips with the LSB, one bit ahead of the next word's MSB.
  task automatic send_word(input logic ch, input logic [31:0] v,
                           input int len, input logic nxt);
    for (int j = len - 1; j >= 0; j--) begin
      send_bit((j == 0) ? nxt : ch, v[j],
               lat_on && (j == 0) && (ch == 1'b1));
    end
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r,
                       input int len);
    send_word(1'b0, l, len, 1'b1);
    send_word(1'b1, r, len, 1'b0);
  endtask

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    q.push_back({l, r});
  endtask

  task automatic settle(input int exp_err, input string tag);
    repeat (12) @(negedge clk);
    chk({tag, "_drain"}, q.size(), 0);
    chk({tag, "_err"}, err_cnt, exp_err);
    err_cnt = 0;
    q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_cnt++;
      if (valid) begin
        chk("excl", err, 1'b0);
        chk("pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          p = q.pop_front();
          chk("left", left, p.l);
          chk("right", right, p.r);
        end
        // The cycle holding the raw BCLK edge counts as the first.
        if (lat_on) chk("latency", cyc - edge_cyc + 1, 4);
      end
    end
  end

  logic [15:0] rw;
  logic [15:0] lr;
  logic [15:0] rr;

  initial begin
    rst  = 1'b1;
    bclk = 1'b0;
    ws   = 1'b0;
    d    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_left", left, 16'h0);
    chk("rst_right", right, 16'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;

    // First frame only syncs: left dropped, right unpaired.
    lat_on = 1'b1;
    frame(32'hA5C3, 32'h0F0F, 16);
    expect_pair(16'hA5C3, 16'h0F0F);
    frame(32'hA5C3, 32'h0F0F, 16);
    expect_pair(16'hA5C3, 16'h0F0F);
    frame(32'hA5C3, 32'h0F0F, 16);
    settle(1, "basic");
    lat_on = 1'b0;
    chk("basic_left", left, 16'hA5C3);
    chk("basic_right", right, 16'h0F0F);

    expect_pair(16'h1234, 16'h8000);
    frame(32'h1234_5678, 32'h8000_FFFF, 32);
    settle(0, "trunc");

    send_word(1'b0, 32'hFFF, 12, 1'b1);
    send_word(1'b1, 32'h5555, 16, 1'b0);
    settle(2, "short");
    chk("short_left", left, 16'h1234);
    chk("short_right", right, 16'h8000);

    // One junk bit with WS low makes a 1-bit right word between lefts.
    send_word(1'b0, 32'h1111, 16, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    expect_pair(16'h2222, 16'h3333);
    send_word(1'b0, 32'h2222, 16, 1'b1);
    send_word(1'b1, 32'h3333, 16, 1'b0);
    settle(1, "dbl_left");

    send_word(1'b0, 32'hAAAA, 16, 1'b1);
    rw = 16'h5A5A;
    for (int j = 15; j >= 8; j--) send_bit(1'b1, rw[j], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_left", left, 16'h0);
    chk("mid_rst_right", right, 16'h0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 7; j >= 0; j--) begin
      send_bit((j == 0) ? 1'b0 : 1'b1, rw[j], 1'b0);
    end
    expect_pair(16'h7E7E, 16'h8181);
    frame(32'h7E7E, 32'h8181, 16);
    settle(1, "reset");
    chk("reset_left", left, 16'h7E7E);
    chk("reset_right", right, 16'h8181);

    half = 2;
    for (int i = 0; i < 100; i++) begin
      lr = 16'($urandom);
      rr = 16'($urandom);
      expect_pair(lr, rr);
      frame({16'h0, lr}, {16'h0, rr}, 16);
    end
    settle(0, "random");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
